// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types, byte constants and helpers for the PS/2 key receiver
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_REL   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // BAT, ACK, echo, resend and error replies: never key events on their own
    function automatic logic is_ctrl_code(input logic [7:0] code);
        return (code == 8'hAA) || (code == 8'hFA) || (code == 8'hEE) ||
               (code == 8'hFE) || (code == 8'h00) || (code == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - synchronises both PS/2 lines, deglitches the clock and strobes its falling edge
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data_sync
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic             clk_meta_q, clk_meta_d;
    logic             clk_sync_q, clk_sync_d;
    logic             data_meta_q, data_meta_d;
    logic             data_sync_q, data_sync_d;
    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fall_q, fall_d;

    always_comb begin
        clk_meta_d  = ps2_clk;
        clk_sync_d  = clk_meta_q;
        data_meta_d = ps2_data;
        data_sync_d = data_meta_q;
        filt_d      = filt_q;
        cnt_d       = '0;
        fall_d      = 1'b0;
        // cnt_q counts consecutive samples that disagree with the filtered level
        if (clk_sync_q != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q;
                fall_d = ~clk_sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // idle PS/2 lines are high, so resetting high avoids a spurious edge
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            filt_q      <= 1'b1;
            cnt_q       <= '0;
            fall_q      <= 1'b0;
        end else begin
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            cnt_q       <= cnt_d;
            fall_q      <= fall_d;
        end
    end

    assign fall      = fall_q;
    assign data_sync = data_sync_q;

endmodule

// File: rtl/ps2_key_rx.sv
// rtl/ps2_key_rx.sv - PS/2 keyboard frame receiver producing the 11-bit ps2_key event word
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 8000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err,
    output logic        busy
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic fall;
    logic data;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_line_filter (
        .clk_sys  (clk_sys),
        .rst      (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fall     (fall),
        .data_sync(data)
    );

    ps2_state_e       state_q, state_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             ext_q, ext_d;
    logic             rel_q, rel_d;
    logic [2:0]       skip_q, skip_d;
    logic [10:0]      key_q, key_d;
    logic             err_q, err_d;

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tmo_d    = tmo_q;
        ext_d    = ext_q;
        rel_d    = rel_q;
        skip_d   = skip_q;
        key_d    = key_q;
        err_d    = 1'b0;

        if (fall) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (!data) begin
                        state_d  = DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d  = {data, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = data;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data && (^{shift_q, parity_q})) begin
                        if (skip_q != 3'd0) begin
                            skip_d = skip_q - 3'd1;
                        end else if (shift_q == PS2_PAUSE) begin
                            // Pause sends E1 plus seven bytes that carry no key event
                            skip_d = 3'd7;
                        end else if (shift_q == PS2_EXT) begin
                            ext_d = 1'b1;
                        end else if (shift_q == PS2_REL) begin
                            rel_d = 1'b1;
                        end else if (!(is_ctrl_code(shift_q) && !ext_q && !rel_q)) begin
                            key_d = {~key_q[10], ~rel_q, ext_q, shift_q};
                            ext_d = 1'b0;
                            rel_d = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                        ext_d = 1'b0;
                        rel_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                state_d = IDLE;
                tmo_d   = '0;
                err_d   = 1'b1;
                ext_d   = 1'b0;
                rel_d   = 1'b0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            bitcnt_q <= 3'd0;
            shift_q  <= 8'h00;
            parity_q <= 1'b0;
            tmo_q    <= '0;
            ext_q    <= 1'b0;
            rel_q    <= 1'b0;
            skip_q   <= 3'd0;
            key_q    <= 11'h000;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tmo_q    <= tmo_d;
            ext_q    <= ext_d;
            rel_q    <= rel_d;
            skip_q   <= skip_d;
            key_q    <= key_d;
            err_q    <= err_d;
        end
    end

    assign ps2_key   = key_q;
    assign frame_err = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb/tb_ps2_key_rx.sv - self-checking bench for ps2_key_rx against a byte-level event model
module tb_ps2_key_rx;

    localparam int H          = 20;
    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 8000;

    logic        clk_sys  = 1'b0;
    logic        reset    = 1'b1;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic        busy;

    ps2_key_rx #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk_sys = ~clk_sys;

    int   n_checks   = 0;
    int   n_fail     = 0;
    int   err_pulses = 0;
    int   err_long   = 0;
    int   cyc        = 0;
    int   last_low   = 0;
    logic err_prev   = 1'b0;

    always @(negedge clk_sys) begin
        cyc = cyc + 1;
        if (frame_err) err_pulses = err_pulses + 1;
        if (frame_err && err_prev) err_long = err_long + 1;
        err_prev = frame_err;
    end

    logic [10:0] m_key;
    logic        m_ext, m_rel;
    int          m_skip;
    int          m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_key  = 11'h000;
        m_ext  = 1'b0;
        m_rel  = 1'b0;
        m_skip = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_skip > 0) m_skip--;
        else if (b == 8'hE1) m_skip = 7;
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_rel = 1'b1;
        else if (!m_ext && !m_rel && (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
        end else begin
            m_key = {~m_key[10], ~m_rel, m_ext, b};
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    task automatic model_bad();
        m_err++;
        m_ext = 1'b0;
        m_rel = 1'b0;
    endtask

    // drives the first nbits of a frame; glitch_at inserts a 3-cycle low pulse in that bit's high phase
    task automatic send_bits(input logic [7:0] b, input logic par_flip, input logic stop,
                             input int nbits, input int glitch_at);
        logic [10:0] bits;
        bits = {stop, (~(^b)) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk_sys);
            ps2_data = bits[i];
            if (i == glitch_at) begin
                repeat (H / 2) @(negedge clk_sys);
                ps2_clk = 1'b0;
                repeat (3) @(negedge clk_sys);
                ps2_clk = 1'b1;
                repeat (H / 2) @(negedge clk_sys);
            end else begin
                repeat (H) @(negedge clk_sys);
            end
            ps2_clk  = 1'b0;
            last_low = cyc;
            repeat (H) @(negedge clk_sys);
            ps2_clk = 1'b1;
        end
        @(negedge clk_sys);
        ps2_data = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input logic par_flip, input logic stop, input int glitch_at);
        send_bits(b, par_flip, stop, 11, glitch_at);
        repeat (4) @(negedge clk_sys);
        if (par_flip || !stop) model_bad();
        else model_byte(b);
    endtask

    task automatic frame_chk(input string tag, input logic [7:0] b);
        frame(b, 1'b0, 1'b1, -1);
        check(tag, 32'(ps2_key), 32'(m_key));
    endtask

    initial begin
        logic [10:0] saved;
        logic [7:0]  rb;
        int          t_start;
        int          elapsed;
        int          r;

        model_reset();
        m_err = 0;
        repeat (5) @(negedge clk_sys);
        check("reset_key", 32'(ps2_key), 32'h000);
        check("reset_err", 32'(frame_err), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk_sys);

        frame_chk("key_1c", 8'h1C);
        check("key_1c_const", 32'(ps2_key), 32'h61C);
        check("busy_after_1c", 32'(busy), 32'h0);

        saved = ps2_key;
        frame(8'hF0, 1'b0, 1'b1, -1);
        check("prefix_f0_hold", 32'(ps2_key), 32'(saved));
        frame_chk("rel_1c", 8'h1C);
        check("rel_1c_const", 32'(ps2_key), 32'h01C);
        frame(8'hE0, 1'b0, 1'b1, -1);
        frame_chk("ext_75", 8'h75);
        check("ext_75_const", 32'(ps2_key), 32'h775);
        frame(8'hE0, 1'b0, 1'b1, -1);
        frame(8'hF0, 1'b0, 1'b1, -1);
        check("prefix_e0f0_hold", 32'(ps2_key), 32'h775);
        frame_chk("ext_rel_75", 8'h75);
        check("ext_rel_75_const", 32'(ps2_key), 32'h175);

        saved = ps2_key;
        frame(8'h1C, 1'b1, 1'b1, -1);
        check("parity_key_hold", 32'(ps2_key), 32'(saved));
        check("parity_err_count", 32'(err_pulses), 32'(m_err));
        frame_chk("after_parity_16", 8'h16);
        check("after_parity_16_const", 32'(ps2_key), 32'h616);

        send_bits(8'h00, 1'b0, 1'b1, 4, -1);
        t_start = err_pulses;
        while (err_pulses == t_start && (cyc - last_low) < TIMEOUT + 200) @(negedge clk_sys);
        elapsed = cyc - last_low;
        model_bad();
        check("tmo_fired", 32'(err_pulses), 32'(m_err));
        check("tmo_not_early", 32'(elapsed >= TIMEOUT), 32'h1);
        check("tmo_not_late", 32'(elapsed <= TIMEOUT + 2 * FILTER_LEN + 8), 32'h1);
        check("tmo_busy", 32'(busy), 32'h0);
        frame_chk("after_tmo_16", 8'h16);

        @(negedge clk_sys);
        ps2_data = 1'b0;
        repeat (4) @(negedge clk_sys);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk_sys);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk_sys);
        check("idle_glitch_busy", 32'(busy), 32'h0);
        ps2_data = 1'b1;
        repeat (5) @(negedge clk_sys);
        frame(8'h33, 1'b0, 1'b1, 0);
        check("glitch_start_33", 32'(ps2_key), 32'(m_key));
        frame(8'h4B, 1'b0, 1'b1, 5);
        check("glitch_mid_4b", 32'(ps2_key), 32'(m_key));
        check("glitch_err_count", 32'(err_pulses), 32'(m_err));

        saved = ps2_key;
        frame(8'hE1, 1'b0, 1'b1, -1);
        frame(8'h14, 1'b0, 1'b1, -1);
        frame(8'h77, 1'b0, 1'b1, -1);
        frame(8'hE1, 1'b0, 1'b1, -1);
        frame(8'hF0, 1'b0, 1'b1, -1);
        frame(8'h14, 1'b0, 1'b1, -1);
        frame(8'hF0, 1'b0, 1'b1, -1);
        frame(8'h77, 1'b0, 1'b1, -1);
        check("pause_hold", 32'(ps2_key), 32'(saved));
        frame(8'hAA, 1'b0, 1'b1, -1);
        check("bat_hold", 32'(ps2_key), 32'(saved));
        frame_chk("after_pause_29", 8'h29);

        send_bits(8'h2A, 1'b0, 1'b1, 5, -1);
        @(negedge clk_sys);
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("midreset_key", 32'(ps2_key), 32'h000);
        check("midreset_err", 32'(frame_err), 32'h0);
        check("midreset_busy", 32'(busy), 32'h0);
        model_reset();
        reset = 1'b0;
        repeat (5) @(negedge clk_sys);
        frame_chk("after_reset_2a", 8'h2A);
        check("after_reset_2a_const", 32'(ps2_key), 32'h62A);

        for (int i = 0; i < 25; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3) rb = (r == 0) ? 8'hE0 : 8'hF0;
            else rb = 8'($urandom_range(0, 255));
            frame(rb, (r == 8) ? 1'b1 : 1'b0, (r == 9) ? 1'b0 : 1'b1, -1);
            check("rand_key", 32'(ps2_key), 32'(m_key));
            check("rand_err", 32'(err_pulses), 32'(m_err));
        end

        check("err_one_cycle", 32'(err_long), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
